rng_debias_packer: RTL and testbench

- Sits between the ring-oscillator entropy source and the UART transmitter of the hardware RNG.
- Synchronises the raw XOR-ed ring-oscillator bit and samples it at a programmable rate.
- Removes bias with a von Neumann extractor, packs the debiased bits into bytes and buffers them in a small FIFO.
- Presents bytes on a valid/ready interface to the UART TX. Also keeps the last four bytes as a 32-bit display word for the hex display.

---
 rtl/rng_pkg.sv | 13 +
 rtl/rng_byte_fifo.sv | 60 ++++++
 rtl/rng_debias_packer.sv | 155 +++++++++++++++
 tb/tb_rng_debias_packer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and constants for the hardware RNG debias/pack datapath.
package rng_pkg;

    localparam int BITS_PER_BYTE = 8;

    typedef logic [BITS_PER_BYTE-1:0] byte_t;

    typedef enum logic {
        PAIR_IDLE,
        PAIR_HAVE_FIRST
    } pair_state_e;

endpackage

// File: rtl/rng_byte_fifo.sv
// Synchronous byte FIFO. A push at full is accepted only when a pop happens in
// the same cycle. head reads zero while empty.
module rng_byte_fifo
    import rng_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [7:0]             push_data,
    output logic                   full,
    input  logic                   pop,
    output logic [7:0]             head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    byte_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            wr_en;
    logic            rd_en;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign level = count;

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; stale contents are never visible because
    // head is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rng_debias_packer.sv
// Ring-oscillator bit synchroniser, sample divider, von Neumann extractor and
// byte packer feeding a byte FIFO toward the UART TX and a 4-byte display word.
module rng_debias_packer
    import rng_pkg::*;
#(
    parameter int SAMPLE_DIV = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        raw_bit,
    input  logic                        enable,
    output logic [7:0]                  out_byte,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 disp_word,
    output logic                        overflow,
    output logic [DROP_CNT_W-1:0]       drop_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);
    localparam logic [2:0] CNT_LAST = 3'(BITS_PER_BYTE - 1);

    logic                     sync_q1;
    logic                     sync_q2;
    logic [7:0]               div_cnt;
    logic                     tick;
    pair_state_e              state_q;
    pair_state_e              state_d;
    logic                     first_q;
    logic                     deb_valid;
    logic                     deb_bit;
    logic [BITS_PER_BYTE-2:0] sr_q;
    logic [2:0]               bit_cnt_q;
    byte_t                    byte_next;
    logic                     byte_done;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic                     push_ok;
    logic                     push_drop;

    // Two-flop synchroniser for the asynchronous ring-oscillator output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw_bit;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (!enable || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = enable && (div_cnt == DIV_LAST);

    // Pair FSM: state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PAIR_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (tick && state_q == PAIR_IDLE) first_q <= sync_q2;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = PAIR_IDLE;
        end else if (tick) begin
            case (state_q)
                PAIR_IDLE:       state_d = PAIR_HAVE_FIRST;
                PAIR_HAVE_FIRST: state_d = PAIR_IDLE;
                default:         state_d = PAIR_IDLE;
            endcase
        end
    end

    // Pairs 01 and 10 yield the first bit; 00 and 11 are discarded.
    always_comb begin
        deb_valid = 1'b0;
        deb_bit   = first_q;
        if (tick && state_q == PAIR_HAVE_FIRST && sync_q2 != first_q) begin
            deb_valid = 1'b1;
        end
    end

    assign byte_next = {sr_q, deb_bit};
    assign byte_done = deb_valid && (bit_cnt_q == CNT_LAST);

    // Only the low seven bits are kept; the eighth bit arrives with the push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else if (deb_valid) begin
            sr_q      <= byte_next[BITS_PER_BYTE-2:0];
            bit_cnt_q <= byte_done ? 3'd0 : bit_cnt_q + 3'd1;
        end
    end

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign push_ok   = byte_done && (!fifo_full || fifo_pop);
    assign push_drop = byte_done && fifo_full && !fifo_pop;

    rng_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (byte_done),
        .push_data (byte_next),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .head      (out_byte),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_word <= '0;
        end else if (push_ok) begin
            disp_word <= {disp_word[23:0], byte_next};
        end
    end

    // Drop statistics are sticky until reset; the counter holds at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (push_drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_rng_debias_packer.sv
// Bench for rng_debias_packer: table-driven byte vectors plus hand-written
// overflow, enable and reset sequences, with a byte scoreboard on the output.
module tb_rng_debias_packer;

    localparam int FIFO_DEPTH = 16;
    localparam int DROP_CNT_W = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        raw_bit;
    logic        enable;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic [31:0] disp_word;
    logic        overflow;
    logic [DROP_CNT_W-1:0] drop_count;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  exp_q [$];
    logic        model_en;
    logic [6:0]  m_sr;
    int          m_cnt;
    logic [31:0] m_disp;
    int          m_drops;
    logic        m_ovf;
    logic        m_pstate;
    logic        m_pfirst;

    typedef struct {
        logic [31:0] raw;
        int          nbits;
        logic [7:0]  exp_byte;
        logic [31:0] exp_disp;
    } vec_t;

    vec_t tbl [6];

    rng_debias_packer #(
        .SAMPLE_DIV (1),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DROP_CNT_W (DROP_CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .raw_bit    (raw_bit),
        .enable     (enable),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .disp_word  (disp_word),
        .overflow   (overflow),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: a pop happens at the next rising edge when valid & ready.
    always begin
        logic [7:0] e;
        @(negedge clk);
        #2;
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_byte: got 0x%0h with nothing expected", out_byte);
            end else begin
                e = exp_q.pop_front();
                check("out_byte", {24'h0, out_byte}, {24'h0, e});
            end
        end
    end

    // Reference for the bit the extractor consumes on one enabled sample.
    task automatic model_step(input logic s);
        logic [7:0] b;
        if (!m_pstate) begin
            m_pfirst = s;
            m_pstate = 1'b1;
        end else begin
            m_pstate = 1'b0;
            if (s != m_pfirst) begin
                b    = {m_sr, m_pfirst};
                m_sr = b[6:0];
                if (m_cnt == 7) begin
                    m_cnt = 0;
                    if (exp_q.size() >= FIFO_DEPTH && !out_ready) begin
                        if (m_drops < 65535) m_drops++;
                        m_ovf = 1'b1;
                    end else begin
                        exp_q.push_back(b);
                        m_disp = {m_disp[23:0], b};
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    // Drives bits[0..n-1]; enable is held low for the first two clocks so the
    // extractor sees bits[0] first once the synchroniser has filled.
    task automatic feed(input logic [511:0] bits, input int n, input logic rdy, input logic rdy_last);
        m_pstate = 1'b0;
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clk);
            raw_bit   = (k < n) ? bits[k] : 1'b0;
            enable    = (k >= 2);
            out_ready = (rdy_last && k == n + 1) ? 1'b1 : rdy;
            if (k >= 2 && model_en) model_step(bits[k-2]);
        end
        @(negedge clk);
        enable    = 1'b0;
        raw_bit   = 1'b0;
        out_ready = rdy;
        #1;
    endtask

    task automatic make_pairs(input int np, output logic [511:0] v);
        logic b;
        v = '0;
        for (int i = 0; i < np; i++) begin
            b        = 1'($urandom_range(0, 1));
            v[2*i]   = b;
            v[2*i+1] = ~b;
        end
    endtask

    initial begin
        logic [511:0] v;
        int           guard;

        tbl[0] = '{32'h0000_5555, 16, 8'h00, 32'h0000_0000};
        tbl[1] = '{32'h0000_AAAA, 16, 8'hFF, 32'h0000_00FF};
        tbl[2] = '{32'h0000_AAAA, 16, 8'hFF, 32'h0000_FFFF};
        tbl[3] = '{32'h0000_AAAA, 16, 8'hFF, 32'h00FF_FFFF};
        tbl[4] = '{32'h0000_AAAA, 16, 8'hFF, 32'hFFFF_FFFF};
        tbl[5] = '{{8'h00, 24'b01_00_10_11_10_01_00_01_11_10_10_01}, 24, 8'h66, 32'hFFFF_FF66};

        reset_n   = 1'b0;
        raw_bit   = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        model_en  = 1'b0;
        m_sr      = '0;
        m_cnt     = 0;
        m_disp    = '0;
        m_drops   = 0;
        m_ovf     = 1'b0;
        m_pstate  = 1'b0;
        m_pfirst  = 1'b0;
        #1;
        check("rst_out_valid",  {31'h0, out_valid}, 32'h0);
        check("rst_out_byte",   {24'h0, out_byte}, 32'h0);
        check("rst_disp_word",  disp_word, 32'h0);
        check("rst_fifo_level", {27'h0, fifo_level}, 32'h0);
        check("rst_drop_count", {16'h0, drop_count}, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Byte-aligned vectors, first raw bit in the MSB of the literal.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v = '0;
            for (int k = 0; k < tbl[i].nbits; k++) v[k] = tbl[i].raw[tbl[i].nbits-1-k];
            exp_q.push_back(tbl[i].exp_byte);
            feed(v, tbl[i].nbits, 1'b1, 1'b0);
            check("tbl_disp_word", disp_word, tbl[i].exp_disp);
        end
        m_disp = disp_word;
        @(negedge clk);
        #1;
        check("tbl_drained_level", {27'h0, fifo_level}, 32'h0);
        check("tbl_overflow", {31'h0, overflow}, 32'h0);

        // Fill with out_ready low: 16 accepted, bytes 17 and 18 dropped.
        model_en = 1'b1;
        make_pairs(18 * 8, v);
        feed(v, 18 * 16, 1'b0, 1'b0);
        check("ovf_level", {27'h0, fifo_level}, 32'd16);
        check("ovf_overflow", {31'h0, overflow}, 32'h1);
        check("ovf_drop_count", {16'h0, drop_count}, 32'd2);
        check("ovf_disp_word", disp_word, m_disp);

        // Byte completes at full exactly when the head is popped.
        make_pairs(8, v);
        feed(v, 16, 1'b0, 1'b1);
        check("fullpop_level", {27'h0, fifo_level}, 32'd16);
        check("fullpop_drop_count", {16'h0, drop_count}, 32'd2);
        check("fullpop_disp_word", disp_word, m_disp);

        // Three debiased bits plus half a pair, then enable drops.
        make_pairs(3, v);
        v[6] = 1'($urandom_range(0, 1));
        feed(v, 7, 1'b0, 1'b0);
        check("en_no_byte_level", {27'h0, fifo_level}, 32'd16);

        // Drain with enable low.
        guard = 0;
        while (exp_q.size() != 0 && guard < 64) begin
            @(negedge clk);
            out_ready = 1'b1;
            guard++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("drain_pending", exp_q.size(), 32'h0);
        check("drain_level", {27'h0, fifo_level}, 32'h0);

        // Four more bits leave the byte short; the fifth completes it.
        make_pairs(4, v);
        feed(v, 8, 1'b0, 1'b0);
        check("en_partial_valid", {31'h0, out_valid}, 32'h0);
        make_pairs(1, v);
        feed(v, 2, 1'b0, 1'b0);
        check("en_complete_level", {27'h0, fifo_level}, 32'd1);
        check("en_disp_word", disp_word, m_disp);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;

        // Five queued bytes plus three bits, then asynchronous reset mid-cycle.
        make_pairs(5 * 8 + 3, v);
        feed(v, 86, 1'b0, 1'b0);
        check("pre_rst_level", {27'h0, fifo_level}, 32'd5);
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid",  {31'h0, out_valid}, 32'h0);
        check("arst_out_byte",   {24'h0, out_byte}, 32'h0);
        check("arst_fifo_level", {27'h0, fifo_level}, 32'h0);
        check("arst_disp_word",  disp_word, 32'h0);
        check("arst_overflow",   {31'h0, overflow}, 32'h0);
        check("arst_drop_count", {16'h0, drop_count}, 32'h0);
        exp_q.delete();
        m_sr    = '0;
        m_cnt   = 0;
        m_disp  = '0;
        m_drops = 0;
        m_ovf   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        make_pairs(16, v);
        feed(v, 32, 1'b1, 1'b0);
        check("post_rst_disp_word", disp_word, m_disp);
        check("post_rst_overflow", {31'h0, overflow}, {31'h0, m_ovf});
        check("post_rst_drop_count", {16'h0, drop_count}, 32'(m_drops));

        guard = 0;
        while (exp_q.size() != 0 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        #1;
        check("final_pending", exp_q.size(), 32'h0);
        check("final_level", {27'h0, fifo_level}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
